// File: rtl/release_req_arbiter_pkg.sv
// release_req_arbiter_pkg
// Shared types for the DCache release arbiter: the held release request,
// the arbiter FSM states, source encodings and the arbitration rule.
package release_req_arbiter_pkg;

    // Default payload widths of a DCache release request
    localparam int REL_ADDR_W = 36;
    localparam int REL_DATA_W = 512;

    // Source of a release: probe replies are non-voluntary, writebacks voluntary
    localparam logic SRC_PROBE = 1'b0;
    localparam logic SRC_WB    = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } rel_arb_state_e;

    typedef struct packed {
        logic [REL_ADDR_W-1:0] addr;
        logic [2:0]            param;
        logic                  voluntary;
        logic                  hasData;
        logic                  dirty;
        logic [REL_DATA_W-1:0] data;
    } release_req_t;

    // Probes win ties unless the writeback has waited too long
    function automatic logic pick_source(input logic probe_valid,
                                         input logic wb_valid,
                                         input logic starve);
        if (wb_valid && (!probe_valid || starve)) begin
            return SRC_WB;
        end
        return SRC_PROBE;
    endfunction

endpackage

// File: rtl/release_starve_ctr.sv
// release_starve_ctr
// Counts consecutive probe grants made while a writeback is waiting and
// raises 'starve' once the limit is reached, so the next tie goes to the
// writeback. Only built when RELEASE_REQ_ARB_STARVE_EN is defined.
`ifdef RELEASE_REQ_ARB_STARVE_EN
module release_starve_ctr
    import release_req_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic probe_grant,
    input  logic wb_grant,
    input  logic wb_valid,
    output logic starve
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt;

    // Saturating count of probe wins over a pending writeback
    always_ff @(posedge clock) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (wb_grant) begin
            starve_cnt <= '0;
        end else if (probe_grant) begin
            if (!wb_valid) begin
                starve_cnt <= '0;
            end else if (starve_cnt != LIMIT) begin
                starve_cnt <= starve_cnt + CNT_W'(1);
            end
        end
    end

    assign starve = (starve_cnt == LIMIT);

endmodule
`endif

// File: rtl/release_req_arbiter.sv
// release_req_arbiter
// Shares the single ReleaseUnit between probe replies and miss-queue
// writebacks. One request is granted in IDLE, held in a register while it is
// offered to ReleaseUnit, and the arbiter stays blocked until io_finish.
// Optional writeback starvation guard: RELEASE_REQ_ARB_STARVE_EN.
module release_req_arbiter
    import release_req_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 36,
    parameter int DATA_W       = 512,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              io_probe_valid,
    output logic              io_probe_ready,
    input  logic [ADDR_W-1:0] io_probe_bits_addr,
    input  logic [2:0]        io_probe_bits_param,
    input  logic              io_probe_bits_hasData,
    input  logic              io_probe_bits_dirty,
    input  logic [DATA_W-1:0] io_probe_bits_data,

    input  logic              io_wb_valid,
    output logic              io_wb_ready,
    input  logic [ADDR_W-1:0] io_wb_bits_addr,
    input  logic [2:0]        io_wb_bits_param,
    input  logic              io_wb_bits_hasData,
    input  logic              io_wb_bits_dirty,
    input  logic [DATA_W-1:0] io_wb_bits_data,

    output logic              io_out_valid,
    input  logic              io_out_ready,
    output logic [ADDR_W-1:0] io_out_bits_addr,
    output logic [2:0]        io_out_bits_param,
    output logic              io_out_bits_voluntary,
    output logic              io_out_bits_hasData,
    output logic              io_out_bits_dirty,
    output logic [DATA_W-1:0] io_out_bits_data,

    input  logic              io_finish,
    output logic              io_busy,
    output logic              io_inflight_src
);

    rel_arb_state_e    state_q;
    rel_arb_state_e    state_d;
    logic              probe_grant;
    logic              wb_grant;
    logic              starve;

    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        param_q;
    logic              voluntary_q;
    logic              has_data_q;
    logic              dirty_q;
    logic [DATA_W-1:0] data_q;
    logic              src_q;

`ifdef RELEASE_REQ_ARB_STARVE_EN
    release_starve_ctr #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve_ctr (
        .clock       (clock),
        .reset       (reset),
        .probe_grant (probe_grant),
        .wb_grant    (wb_grant),
        .wb_valid    (io_wb_valid),
        .starve      (starve)
    );
`else
    logic unused_starve_limit;
    assign starve              = 1'b0;
    assign unused_starve_limit = STARVE_LIMIT[0];
`endif

    // State register; reset abandons any held request
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Grant selection in IDLE, then hold until handshake and finish
    always_comb begin
        state_d      = state_q;
        probe_grant  = 1'b0;
        wb_grant     = 1'b0;
        io_out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (!reset && (io_probe_valid || io_wb_valid)) begin
                    if (pick_source(io_probe_valid, io_wb_valid, starve) == SRC_WB) begin
                        wb_grant = 1'b1;
                    end else begin
                        probe_grant = 1'b1;
                    end
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                io_out_valid = 1'b1;
                if (io_out_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (io_finish) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Holding register, loaded only on a grant
    always_ff @(posedge clock) begin
        if (reset) begin
            addr_q      <= '0;
            param_q     <= '0;
            voluntary_q <= 1'b0;
            has_data_q  <= 1'b0;
            dirty_q     <= 1'b0;
            data_q      <= '0;
            src_q       <= SRC_PROBE;
        end else if (probe_grant) begin
            addr_q      <= io_probe_bits_addr;
            param_q     <= io_probe_bits_param;
            voluntary_q <= SRC_PROBE;
            has_data_q  <= io_probe_bits_hasData;
            dirty_q     <= io_probe_bits_dirty;
            data_q      <= io_probe_bits_data;
            src_q       <= SRC_PROBE;
        end else if (wb_grant) begin
            addr_q      <= io_wb_bits_addr;
            param_q     <= io_wb_bits_param;
            voluntary_q <= SRC_WB;
            has_data_q  <= io_wb_bits_hasData;
            dirty_q     <= io_wb_bits_dirty;
            data_q      <= io_wb_bits_data;
            src_q       <= SRC_WB;
        end
    end

    assign io_probe_ready        = probe_grant;
    assign io_wb_ready           = wb_grant;
    assign io_busy               = (state_q != IDLE);
    assign io_inflight_src       = src_q;
    assign io_out_bits_addr      = addr_q;
    assign io_out_bits_param     = param_q;
    assign io_out_bits_voluntary = voluntary_q;
    assign io_out_bits_hasData   = has_data_q;
    assign io_out_bits_dirty     = dirty_q;
    assign io_out_bits_data      = data_q;

endmodule

// File: tb/tb_release_req_arbiter.sv
// tb_release_req_arbiter
// Directed scenarios plus a randomized run against a transaction-level model
// of the release arbiter (busy / handed-off flags and a wait counter).
module tb_release_req_arbiter;

    localparam int ADDR_W       = 36;
    localparam int DATA_W       = 512;
    localparam int STARVE_LIMIT = 2;

    logic              clock = 1'b0;
    logic              reset;
    logic              io_probe_valid, io_probe_ready;
    logic [ADDR_W-1:0] io_probe_bits_addr;
    logic [2:0]        io_probe_bits_param;
    logic              io_probe_bits_hasData, io_probe_bits_dirty;
    logic [DATA_W-1:0] io_probe_bits_data;
    logic              io_wb_valid, io_wb_ready;
    logic [ADDR_W-1:0] io_wb_bits_addr;
    logic [2:0]        io_wb_bits_param;
    logic              io_wb_bits_hasData, io_wb_bits_dirty;
    logic [DATA_W-1:0] io_wb_bits_data;
    logic              io_out_valid, io_out_ready;
    logic [ADDR_W-1:0] io_out_bits_addr;
    logic [2:0]        io_out_bits_param;
    logic              io_out_bits_voluntary, io_out_bits_hasData, io_out_bits_dirty;
    logic [DATA_W-1:0] io_out_bits_data;
    logic              io_finish, io_busy, io_inflight_src;

    int vec_count  = 0;
    int miss_count = 0;

    // Reference model: a request is either absent, offered, or handed off
    bit                m_busy;
    bit                m_acked;
    int                m_starve;
    bit                m_pick_wb;
    logic [ADDR_W-1:0] m_addr;
    logic [2:0]        m_param;
    logic              m_vol, m_has, m_dirty;
    logic [DATA_W-1:0] m_data;

    release_req_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clock(clock), .reset(reset),
        .io_probe_valid(io_probe_valid), .io_probe_ready(io_probe_ready),
        .io_probe_bits_addr(io_probe_bits_addr), .io_probe_bits_param(io_probe_bits_param),
        .io_probe_bits_hasData(io_probe_bits_hasData), .io_probe_bits_dirty(io_probe_bits_dirty),
        .io_probe_bits_data(io_probe_bits_data),
        .io_wb_valid(io_wb_valid), .io_wb_ready(io_wb_ready),
        .io_wb_bits_addr(io_wb_bits_addr), .io_wb_bits_param(io_wb_bits_param),
        .io_wb_bits_hasData(io_wb_bits_hasData), .io_wb_bits_dirty(io_wb_bits_dirty),
        .io_wb_bits_data(io_wb_bits_data),
        .io_out_valid(io_out_valid), .io_out_ready(io_out_ready),
        .io_out_bits_addr(io_out_bits_addr), .io_out_bits_param(io_out_bits_param),
        .io_out_bits_voluntary(io_out_bits_voluntary), .io_out_bits_hasData(io_out_bits_hasData),
        .io_out_bits_dirty(io_out_bits_dirty), .io_out_bits_data(io_out_bits_data),
        .io_finish(io_finish), .io_busy(io_busy), .io_inflight_src(io_inflight_src)
    );

    always #5 clock = ~clock;

    function automatic logic [ADDR_W-1:0] rand_addr();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[ADDR_W-1:0];
    endfunction

    function automatic logic [DATA_W-1:0] rand_data();
        logic [DATA_W-1:0] d;
        for (int i = 0; i < DATA_W / 32; i++) d[i*32 +: 32] = $urandom();
        return d;
    endfunction

    // Writeback wins if it is alone, or if it has waited through the limit
    function automatic bit model_pick_wb(input bit pv, input bit wv);
        bit fire;
        fire = 1'b0;
`ifdef RELEASE_REQ_ARB_STARVE_EN
        fire = (m_starve >= STARVE_LIMIT);
`endif
        return wv && (!pv || fire);
    endfunction

    // Model update at each active edge
    always @(posedge clock) begin
        if (reset) begin
            m_busy = 0; m_acked = 0; m_starve = 0;
            m_addr = '0; m_param = '0; m_vol = 0; m_has = 0; m_dirty = 0; m_data = '0;
        end else if (!m_busy) begin
            if (io_probe_valid || io_wb_valid) begin
                m_pick_wb = model_pick_wb(io_probe_valid, io_wb_valid);
                if (m_pick_wb) begin
                    m_addr = io_wb_bits_addr; m_param = io_wb_bits_param; m_vol = 1;
                    m_has = io_wb_bits_hasData; m_dirty = io_wb_bits_dirty; m_data = io_wb_bits_data;
                    m_starve = 0;
                end else begin
                    m_addr = io_probe_bits_addr; m_param = io_probe_bits_param; m_vol = 0;
                    m_has = io_probe_bits_hasData; m_dirty = io_probe_bits_dirty; m_data = io_probe_bits_data;
                    m_starve = io_wb_valid ? ((m_starve < STARVE_LIMIT) ? m_starve + 1 : m_starve) : 0;
                end
                m_busy = 1; m_acked = 0;
            end
        end else if (!m_acked) begin
            if (io_out_ready) m_acked = 1;
        end else if (io_finish) begin
            m_busy = 0;
        end
    end

    task automatic test_reset();
        reset = 1; io_probe_valid = 1; io_wb_valid = 1; io_out_ready = 1; io_finish = 1;
        repeat (2) begin
            @(negedge clock); #1;
            vec_count++; if (io_probe_ready !== 1'b0) begin miss_count++; $display("[TB] FAIL rst_probe_ready: got %b want 0", io_probe_ready); end
            vec_count++; if (io_wb_ready !== 1'b0) begin miss_count++; $display("[TB] FAIL rst_wb_ready: got %b want 0", io_wb_ready); end
            vec_count++; if (io_out_valid !== 1'b0) begin miss_count++; $display("[TB] FAIL rst_out_valid: got %b want 0", io_out_valid); end
            vec_count++; if (io_busy !== 1'b0) begin miss_count++; $display("[TB] FAIL rst_busy: got %b want 0", io_busy); end
        end
        vec_count++; if (io_inflight_src !== 1'b0) begin miss_count++; $display("[TB] FAIL rst_src: got %b want 0", io_inflight_src); end
        vec_count++; if (io_out_bits_addr !== '0 || io_out_bits_data !== '0 || io_out_bits_voluntary !== 1'b0)
            begin miss_count++; $display("[TB] FAIL rst_payload: got addr %h vol %b want 0", io_out_bits_addr, io_out_bits_voluntary); end
        @(negedge clock);
        reset = 0; io_probe_valid = 0; io_wb_valid = 0; io_out_ready = 0; io_finish = 0;
    endtask

    task automatic test_single_wb();
        logic [DATA_W-1:0] d;
        d = rand_data();
        @(negedge clock);
        io_wb_valid = 1; io_wb_bits_addr = 36'h8_0000_0040; io_wb_bits_param = 3'd2;
        io_wb_bits_hasData = 1; io_wb_bits_dirty = 1; io_wb_bits_data = d; #1;
        vec_count++; if (io_wb_ready !== 1'b1 || io_probe_ready !== 1'b0) begin miss_count++; $display("[TB] FAIL wb_grant: got wb %b probe %b want 1 0", io_wb_ready, io_probe_ready); end
        vec_count++; if (io_out_valid !== 1'b0) begin miss_count++; $display("[TB] FAIL wb_latency: got out_valid %b want 0", io_out_valid); end
        @(negedge clock);
        io_wb_valid = 0; io_wb_bits_data = ~d; io_out_ready = 1; #1;
        vec_count++; if (io_out_valid !== 1'b1 || io_busy !== 1'b1) begin miss_count++; $display("[TB] FAIL wb_issue: got valid %b busy %b want 1 1", io_out_valid, io_busy); end
        vec_count++; if (io_out_bits_voluntary !== 1'b1 || io_inflight_src !== 1'b1) begin miss_count++; $display("[TB] FAIL wb_vol: got vol %b src %b want 1 1", io_out_bits_voluntary, io_inflight_src); end
        vec_count++; if (io_out_bits_addr !== 36'h8_0000_0040 || io_out_bits_param !== 3'd2) begin miss_count++; $display("[TB] FAIL wb_addr: got %h/%0d want 800000040/2", io_out_bits_addr, io_out_bits_param); end
        vec_count++; if (io_out_bits_data !== d || io_out_bits_hasData !== 1'b1 || io_out_bits_dirty !== 1'b1) begin miss_count++; $display("[TB] FAIL wb_data: got %h want %h", io_out_bits_data, d); end
        @(negedge clock);
        io_out_ready = 0; #1;
        vec_count++; if (io_out_valid !== 1'b0 || io_busy !== 1'b1) begin miss_count++; $display("[TB] FAIL wb_wait: got valid %b busy %b want 0 1", io_out_valid, io_busy); end
        @(negedge clock);
        io_finish = 1; #1;
        vec_count++; if (io_busy !== 1'b1) begin miss_count++; $display("[TB] FAIL wb_finish_cycle: got busy %b want 1", io_busy); end
        @(negedge clock);
        io_finish = 0; #1;
        vec_count++; if (io_busy !== 1'b0 || io_out_valid !== 1'b0) begin miss_count++; $display("[TB] FAIL wb_idle: got busy %b valid %b want 0 0", io_busy, io_out_valid); end
    endtask

    task automatic test_priority();
        @(negedge clock);
        io_probe_valid = 1; io_probe_bits_addr = 36'h1000; io_probe_bits_param = 3'd1;
        io_probe_bits_hasData = 0; io_probe_bits_dirty = 0;
        io_wb_valid = 1; io_wb_bits_addr = 36'h2000; io_wb_bits_param = 3'd0;
        io_wb_bits_hasData = 1; io_wb_bits_dirty = 1; #1;
        vec_count++; if (io_probe_ready !== 1'b1 || io_wb_ready !== 1'b0) begin miss_count++; $display("[TB] FAIL prio_grant: got probe %b wb %b want 1 0", io_probe_ready, io_wb_ready); end
        @(negedge clock);
        io_probe_valid = 0; io_out_ready = 1; #1;
        vec_count++; if (io_out_bits_addr !== 36'h1000 || io_out_bits_param !== 3'd1 || io_out_bits_hasData !== 1'b0) begin miss_count++; $display("[TB] FAIL prio_probe_bits: got %h/%0d want 1000/1", io_out_bits_addr, io_out_bits_param); end
        vec_count++; if (io_out_bits_voluntary !== 1'b0 || io_inflight_src !== 1'b0) begin miss_count++; $display("[TB] FAIL prio_probe_src: got vol %b src %b want 0 0", io_out_bits_voluntary, io_inflight_src); end
        vec_count++; if (io_wb_ready !== 1'b0) begin miss_count++; $display("[TB] FAIL prio_wb_blocked: got %b want 0", io_wb_ready); end
        @(negedge clock);
        io_out_ready = 0; io_finish = 1;
        @(negedge clock);
        io_finish = 0; #1;
        vec_count++; if (io_wb_ready !== 1'b1 || io_busy !== 1'b0) begin miss_count++; $display("[TB] FAIL prio_wb_next: got ready %b busy %b want 1 0", io_wb_ready, io_busy); end
        @(negedge clock);
        io_wb_valid = 0; #1;
        vec_count++; if (io_out_bits_addr !== 36'h2000 || io_out_bits_voluntary !== 1'b1 || io_inflight_src !== 1'b1) begin miss_count++; $display("[TB] FAIL prio_wb_bits: got %h vol %b want 2000 1", io_out_bits_addr, io_out_bits_voluntary); end
        @(negedge clock); io_out_ready = 1;
        @(negedge clock); io_out_ready = 0; io_finish = 1;
        @(negedge clock); io_finish = 0;
    endtask

    task automatic test_backpressure();
        #1;
        vec_count++; if (io_busy !== 1'b0) begin miss_count++; $display("[TB] FAIL bp_start_idle: got busy %b want 0", io_busy); end
        @(negedge clock);
        io_finish = 1; #1;
        @(negedge clock);
        io_finish = 0; #1;
        vec_count++; if (io_busy !== 1'b0 || io_out_valid !== 1'b0) begin miss_count++; $display("[TB] FAIL idle_finish: got busy %b valid %b want 0 0", io_busy, io_out_valid); end
        @(negedge clock);
        io_probe_valid = 1; io_probe_bits_addr = 36'h3000_0080; io_wb_valid = 1; #1;
        vec_count++; if (io_probe_ready !== 1'b1) begin miss_count++; $display("[TB] FAIL bp_grant: got %b want 1", io_probe_ready); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            io_out_ready = 0; io_finish = (i == 2 || i == 3); io_probe_bits_addr = rand_addr(); #1;
            vec_count++; if (io_out_valid !== 1'b1 || io_out_bits_addr !== 36'h3000_0080) begin miss_count++; $display("[TB] FAIL bp_hold: cycle %0d got valid %b addr %h want 1 300000080", i, io_out_valid, io_out_bits_addr); end
            vec_count++; if (io_probe_ready !== 1'b0 || io_wb_ready !== 1'b0) begin miss_count++; $display("[TB] FAIL bp_readies: cycle %0d got %b %b want 0 0", i, io_probe_ready, io_wb_ready); end
        end
        @(negedge clock);
        io_finish = 0; io_out_ready = 1; #1;
        vec_count++; if (io_out_valid !== 1'b1) begin miss_count++; $display("[TB] FAIL bp_after_finish: got %b want 1", io_out_valid); end
        @(negedge clock);
        io_out_ready = 0; io_finish = 1; io_probe_valid = 0; io_wb_valid = 0; #1;
        vec_count++; if (io_out_valid !== 1'b0 || io_busy !== 1'b1) begin miss_count++; $display("[TB] FAIL bp_wait: got valid %b busy %b want 0 1", io_out_valid, io_busy); end
        @(negedge clock);
        io_finish = 0;
    endtask

    task automatic test_starvation();
        bit exp_wb;
        @(negedge clock); reset = 1;
        @(negedge clock); reset = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            io_finish = 0; io_probe_valid = 1; io_wb_valid = 1; #1;
`ifdef RELEASE_REQ_ARB_STARVE_EN
            exp_wb = (k == 2);
`else
            exp_wb = 1'b0;
`endif
            vec_count++; if (io_wb_ready !== exp_wb || io_probe_ready !== !exp_wb) begin miss_count++; $display("[TB] FAIL starve_grant%0d: got wb %b probe %b want wb %b", k, io_wb_ready, io_probe_ready, exp_wb); end
            @(negedge clock);
            io_out_ready = 1; #1;
            vec_count++; if (io_out_bits_voluntary !== exp_wb) begin miss_count++; $display("[TB] FAIL starve_vol%0d: got %b want %b", k, io_out_bits_voluntary, exp_wb); end
            @(negedge clock);
            io_out_ready = 0; io_finish = 1;
        end
        @(negedge clock);
        io_finish = 0; io_probe_valid = 0; io_wb_valid = 0; #1;
        vec_count++; if (io_busy !== 1'b0) begin miss_count++; $display("[TB] FAIL starve_end: got busy %b want 0", io_busy); end
    endtask

    task automatic test_reset_mid();
        @(negedge clock);
        io_probe_valid = 1; io_probe_bits_addr = 36'h4440; #1;
        @(negedge clock);
        io_probe_valid = 0; io_out_ready = 1;
        @(negedge clock);
        io_out_ready = 0; #1;
        vec_count++; if (io_busy !== 1'b1 || io_out_valid !== 1'b0) begin miss_count++; $display("[TB] FAIL mid_wait: got busy %b valid %b want 1 0", io_busy, io_out_valid); end
        @(negedge clock);
        reset = 1; io_probe_valid = 1; #1;
        vec_count++; if (io_probe_ready !== 1'b0) begin miss_count++; $display("[TB] FAIL mid_rst_ready: got %b want 0", io_probe_ready); end
        @(negedge clock);
        reset = 0; io_probe_bits_addr = 36'h5550; #1;
        vec_count++; if (io_busy !== 1'b0 || io_out_valid !== 1'b0 || io_inflight_src !== 1'b0 || io_out_bits_addr !== '0) begin miss_count++; $display("[TB] FAIL mid_rst_state: got busy %b valid %b addr %h want 0 0 0", io_busy, io_out_valid, io_out_bits_addr); end
        vec_count++; if (io_probe_ready !== 1'b1) begin miss_count++; $display("[TB] FAIL mid_regrant: got %b want 1", io_probe_ready); end
        @(negedge clock);
        io_probe_valid = 0; #1;
        vec_count++; if (io_out_valid !== 1'b1 || io_out_bits_addr !== 36'h5550) begin miss_count++; $display("[TB] FAIL mid_reissue: got valid %b addr %h want 1 5550", io_out_valid, io_out_bits_addr); end
        @(negedge clock); io_out_ready = 1;
        @(negedge clock); io_out_ready = 0; io_finish = 1;
        @(negedge clock); io_finish = 0;
    endtask

    task automatic test_random();
        bit exp_wb, can_grant, exp_pr, exp_wr, exp_ov;
        for (int c = 0; c < 600; c++) begin
            @(negedge clock);
            reset = ($urandom_range(0, 99) == 0);
            io_probe_valid = ($urandom_range(0, 1) == 1);
            io_wb_valid = ($urandom_range(0, 3) != 0);
            io_probe_bits_addr = rand_addr(); io_probe_bits_param = 3'($urandom_range(0, 7));
            io_probe_bits_hasData = ($urandom_range(0, 1) == 1); io_probe_bits_dirty = ($urandom_range(0, 1) == 1);
            io_probe_bits_data = rand_data();
            io_wb_bits_addr = rand_addr(); io_wb_bits_param = 3'($urandom_range(0, 7));
            io_wb_bits_hasData = ($urandom_range(0, 1) == 1); io_wb_bits_dirty = ($urandom_range(0, 1) == 1);
            io_wb_bits_data = rand_data();
            io_out_ready = ($urandom_range(0, 1) == 1);
            io_finish = ($urandom_range(0, 2) == 0);
            #1;
            exp_wb = model_pick_wb(io_probe_valid, io_wb_valid);
            can_grant = !reset && !m_busy && (io_probe_valid || io_wb_valid);
            exp_pr = can_grant && !exp_wb;
            exp_wr = can_grant && exp_wb;
            exp_ov = m_busy && !m_acked;
            vec_count++; if (io_probe_ready !== exp_pr || io_wb_ready !== exp_wr) begin miss_count++; $display("[TB] FAIL rnd_ready c%0d: got probe %b wb %b want %b %b", c, io_probe_ready, io_wb_ready, exp_pr, exp_wr); end
            vec_count++; if (io_out_valid !== exp_ov || io_busy !== m_busy) begin miss_count++; $display("[TB] FAIL rnd_valid c%0d: got valid %b busy %b want %b %b", c, io_out_valid, io_busy, exp_ov, m_busy); end
            if (m_busy) begin
                vec_count++; if (io_out_bits_addr !== m_addr || io_out_bits_param !== m_param) begin miss_count++; $display("[TB] FAIL rnd_addr c%0d: got %h/%0d want %h/%0d", c, io_out_bits_addr, io_out_bits_param, m_addr, m_param); end
                vec_count++; if (io_out_bits_voluntary !== m_vol || io_inflight_src !== m_vol) begin miss_count++; $display("[TB] FAIL rnd_src c%0d: got vol %b src %b want %b", c, io_out_bits_voluntary, io_inflight_src, m_vol); end
                vec_count++; if (io_out_bits_hasData !== m_has || io_out_bits_dirty !== m_dirty || io_out_bits_data !== m_data) begin miss_count++; $display("[TB] FAIL rnd_data c%0d: got has %b dirty %b want %b %b", c, io_out_bits_hasData, io_out_bits_dirty, m_has, m_dirty); end
            end
        end
        @(negedge clock);
        reset = 0; io_probe_valid = 0; io_wb_valid = 0; io_out_ready = 0; io_finish = 0;
    endtask

    initial begin
        reset = 1; io_probe_valid = 0; io_wb_valid = 0; io_out_ready = 0; io_finish = 0;
        io_probe_bits_addr = '0; io_probe_bits_param = '0; io_probe_bits_hasData = 0;
        io_probe_bits_dirty = 0; io_probe_bits_data = '0;
        io_wb_bits_addr = '0; io_wb_bits_param = '0; io_wb_bits_hasData = 0;
        io_wb_bits_dirty = 0; io_wb_bits_data = '0;
        test_reset();
        test_single_wb();
        test_priority();
        test_backpressure();
        test_starvation();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule

// File: doc/release_req_arbiter.md
# release_req_arbiter

Shares the single ReleaseUnit between the two producers of TileLink C-channel releases in the DCache: probe replies (ProbeAck/ProbeAckData, non-voluntary) and miss-queue writebacks (Release/ReleaseData, voluntary). It selects one request and holds it in a register while presenting it to ReleaseUnit. It then stays blocked until ReleaseUnit pulses `finish`, so only one release is ever in flight. Probes have priority, with an optional starvation guard for writebacks.

## Interface
Parameters:
- ADDR_W, 36, block address width
- DATA_W, 512, full-block data width
- STARVE_LIMIT, 8, consecutive probe grants tolerated while a writeback waits (≥1)

Ports:
- clock  in  1  single clock
- reset  in  1  synchronous, active-high
- io_probe_valid / io_probe_ready  in/out  1  probe-reply request handshake
- io_probe_bits_{addr,param,hasData,dirty,data}  in  ADDR_W/3/1/1/DATA_W  probe-reply payload (voluntary implied 0)
- io_wb_valid / io_wb_ready  in/out  1  writeback request handshake
- io_wb_bits_{addr,param,hasData,dirty,data}  in  ADDR_W/3/1/1/DATA_W  writeback payload (voluntary implied 1)
- io_out_valid / io_out_ready  out/in  1  request to ReleaseUnit `io_req`
- io_out_bits_{addr,param,voluntary,hasData,dirty,data}  out  ADDR_W/3/1/1/1/DATA_W  registered request
- io_finish  in  1  ReleaseUnit `io_finish` pulse
- io_busy  out  1  state ≠ IDLE
- io_inflight_src  out  1  source of held request: 0 probe, 1 writeback

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - If any input is valid, grant exactly one; its ready=1 in this cycle only.
  - Latch the payload, set voluntary = source, set io_inflight_src, then go to ISSUE.
- ISSUE:
  - io_out_valid=1, bits come from the holding register and stay stable.
  - On io_out_ready go to WAIT.
- WAIT:
  - Wait for io_finish, then return to IDLE.
- Both input readies are 0 in ISSUE and WAIT.
- Arbitration in IDLE:
  - Only one valid: that one wins.
  - Both valid: probe wins unless the starvation guard fires (see Configuration).
- io_finish outside WAIT is ignored; no state change.
- io_finish is never expected in the same cycle as the ISSUE handshake. If both arrive in that cycle, the handshake takes effect and the finish is dropped.
- Payload register is loaded only on a grant. Its contents are don't-care when io_busy=0.

## Timing
- Reset values:
  - state = IDLE, io_out_valid = 0, io_busy = 0, io_inflight_src = 0
  - io_probe_ready = 0 and io_wb_ready = 0 during reset
  - starvation counter = 0
  - out payload = 0
- Grant in cycle N → io_out_valid=1 in cycle N+1 (1-cycle latency).
- io_out_ready already high → out handshake in cycle N+1, WAIT from N+2.
- io_finish in cycle M → IDLE in M+1; the next grant can happen in M+1. Back-to-back releases therefore cost one idle cycle after finish.
- io_out_valid stays high until handshake; no withdrawal.
- Reset mid-operation: abandon the held request, go to IDLE, clear the counter. Upstream must re-issue.

## Configuration
- `RELEASE_REQ_ARB_STARVE_EN` defined:
  - Counter `starve_cnt`, width $clog2(STARVE_LIMIT+1), saturating.
  - Increments on each probe grant made while io_wb_valid=1.
  - Clears on any writeback grant, and on a probe grant made while io_wb_valid=0.
  - When starve_cnt == STARVE_LIMIT and both inputs are valid, the writeback wins and the counter clears.
- Undefined: no counter; strict probe priority; a writeback can starve indefinitely.

## Structure
- Package `release_req_arbiter_pkg`:
  - `release_req_t` struct {addr, param, voluntary, hasData, dirty, data}
  - `rel_arb_state_e` enum {IDLE, ISSUE, WAIT}
  - `SRC_PROBE`=1'b0, `SRC_WB`=1'b1
- One natural sub-module: `release_starve_ctr`, the saturating counter plus the `starve` flag. It is instantiated only under the macro.

## Test plan
- Single writeback: addr=0x8_0000_0040, hasData=1, dirty=1. Expect out_valid in N+1 with voluntary=1 and data echoed; out_ready=1 → WAIT; finish → IDLE next cycle; io_busy low after.
- Simultaneous probe (addr 0x1000, param=3'd1, hasData=0) and writeback (addr 0x2000). Expect the probe to win first (voluntary=0, inflight_src=0). After finish, the writeback is granted in the next IDLE cycle.
- Back-pressure: out_ready held 0 for 5 cycles during ISSUE. Expect out bits stable, both input readies 0, no second grant.
- Spurious finish in IDLE and in ISSUE. Expect no state change and out_valid unaffected.
- With `RELEASE_REQ_ARB_STARVE_EN`, STARVE_LIMIT=2, writeback held valid, probes back-to-back. Expect grant order probe, probe, writeback. Without the macro, all probes win.
- Reset asserted during WAIT. Expect IDLE, out_valid=0, counter 0 in the next cycle; a fresh probe is granted normally afterwards.
